vram_line_fetcher: RTL
======================

// Module: vram_line_fetcher
// PURPOSE
//  Burst read engine on one 32-bit read-only port (if1/if2/if3) of the VRAM arbiter.
//  On start it fetches a run of consecutive 32-bit words (one scanline of tile map or bitmap).
//  Words are buffered in a small FIFO and handed to the layer renderer over a valid/ready stream.
//  Sustains one word/clk while the arbiter keeps granting.
// PARAMETERS
//  FIFO_DEPTH  8  buffer entries, power of two, >=4
//  LEN_W       8  width of word_count
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      async active-low reset
//  start        in   1      1-clk pulse: begin burst (ignored unless idle)
//  start_addr   in   15     first word address (byte address >> 2)
//  word_count   in   LEN_W  words to fetch; 0 = complete immediately
//  abort        in   1      cancel burst, flush FIFO
//  busy         out  1      burst in progress (incl. flush)
//  done         out  1      1-clk pulse when last word has been written into the FIFO
//  vram_addr    out  15     to ifN_addr
//  vram_strobe  out  1      to ifN_strobe
//  vram_ack     in   1      from ifN_ack
//  vram_rddata  in   32     from ifN_rddata, valid only while vram_ack=1
//  rd_data      out  32     FIFO head word
//  rd_valid     out  1      FIFO not empty
//  rd_ready     in   1      consumer pops the head when rd_valid & rd_ready
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, FIFO empty, busy=0, done=0, strobe=0, addr=0, rd_valid=0.
//  Arbiter contract: a grant in cycle c (strobe=1, no higher-priority port) gives ack=1 in c+1.
//   The ack carries data for the address driven in c. Grants are invisible, acks are not.
//  Addressing: registers base, issued (words acked), pending (words left to request).
//   vram_addr = base + issued + vram_ack (combinational), 15-bit wrap 0x7FFF->0x0000.
//   This presents the next word already in the ack cycle: no duplicate reads, no bubbles.
//  Strobe: vram_strobe = (state==FETCH) & (pending_eff>0) & (free_slots >= 2).
//   pending_eff = pending - vram_ack.
//   free_slots excludes any word being written this cycle.
//   The 2-slot margin covers the one read possibly in flight, so the FIFO never overflows.
//  Ack handling in FETCH: vram_ack=1 -> push vram_rddata, issued+1, pending-1.
//   Ack in any other state is discarded.
//  States:
//   IDLE: on start (abort=0): latch base=start_addr, pending=word_count, issued=0.
//    word_count!=0 -> FETCH; word_count==0 -> done=1 next clk, stay IDLE.
//   FETCH: when last ack is pushed (pending 1->0) -> done=1 same edge, -> IDLE.
//    abort=1 -> FLUSH.
//   FLUSH: strobe=0, FIFO cleared, one ack arriving this cycle is discarded -> IDLE after 1 clk.
//  busy = (state != IDLE).
//  done never asserts for an aborted burst.
//  FIFO: push/pop same cycle allowed at any level, including full (count unchanged).
//   Pop on empty ignored. rd_data is undefined (holds last) when rd_valid=0.
//   FIFO content persists after done until consumed. A new start does not clear it.
//  Simultaneous events:
//   abort beats start and beats ack.
//   start while busy is ignored.
//   abort in IDLE clears the FIFO, no FLUSH state.
//  done and rd_valid are registered outputs. vram_addr and vram_strobe are combinational from regs + vram_ack.
// STRUCTURE
//  Shared package: state encoding (IDLE/FETCH/FLUSH), VRAM_WADDR_W=15, VRAM_WDATA_W=32.
//  One sub-module: sync_fifo (WIDTH=32, DEPTH=FIFO_DEPTH, flush input, count output).
//  Address adder and control FSM stay in this module.
// TESTING
//  1 Stream: start_addr=0x0100, count=4, ack every clk after strobe, rd_ready=1.
//    -> addrs 0x100..0x103 on consecutive clks; 4 words out in order; done 1 clk after 4th ack.
//  2 Stalled grant: count=3, ack held 0 for 5 clks mid-burst.
//    -> vram_addr holds the current word; no address skipped or repeated; 3 words delivered.
//  3 Backpressure: DEPTH=8, count=20, rd_ready=0.
//    -> strobe drops with 6 words stored (+1 possibly in flight) and no overflow.
//    -> rd_ready=1 resumes the burst; all 20 words delivered in order.
//  4 Wrap: start_addr=0x7FFE, count=4 -> addrs 0x7FFE, 0x7FFF, 0x0000, 0x0001.
//  5 Abort: abort asserted in the same clk as an ack.
//    -> FLUSH 1 clk; next-clk ack discarded; FIFO empty; no done; new start accepted the clk after.
//  6 Edge cases: count=0 -> done pulse, no strobe.
//    start while busy -> ignored.
//    rst_n low mid-burst -> all outputs reset immediately.

Source files
------------

// File: rtl/vram_line_fetcher_pkg.sv
// Shared definitions for the VRAM line fetcher: bus widths and FSM states.
package vram_line_fetcher_pkg;

    localparam int unsigned VRAM_WADDR_W = 15;
    localparam int unsigned VRAM_WDATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/vram_line_fetcher_sync_fifo.sv
// Single-clock FIFO with synchronous flush, occupancy count and registered valid.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic             do_push, do_pop;

    // Pop only a present word; push when space exists or a pop frees one this cycle.
    assign do_pop  = pop & (count_q != '0);
    assign do_push = push & ((count_q < CW'(DEPTH)) | do_pop);

    // Next-state for pointers, count and valid; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        valid_d = (count_d != '0);
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Storage array; contents need no reset since valid gates their use.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= push_data;
    end

    assign rd_data  = mem[rd_ptr_q];
    assign rd_valid = valid_q;
    assign count    = count_q;

endmodule

// File: rtl/vram_line_fetcher.sv
// Burst read engine: fetches a run of consecutive VRAM words into a FIFO for the renderer.
module vram_line_fetcher
    import vram_line_fetcher_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LEN_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [VRAM_WADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]        word_count,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [VRAM_WADDR_W-1:0] vram_addr,
    output logic                    vram_strobe,
    input  logic                    vram_ack,
    input  logic [VRAM_WDATA_W-1:0] vram_rddata,
    output logic [VRAM_WDATA_W-1:0] rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e            state_q, state_d;
    logic [VRAM_WADDR_W-1:0] base_q, base_d;
    logic [VRAM_WADDR_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0]        pending_q, pending_d;
    logic                    done_q, done_d;

    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W:0]          used_after;
    logic [LEN_W-1:0]        pending_eff;
    logic                    push, fifo_flush;

    // Acks only count while fetching, and abort wins over a coincident ack.
    assign push       = (state_q == ST_FETCH) & vram_ack & ~abort;
    assign fifo_flush = abort | (state_q == ST_FLUSH);

    // Address leads by the acked word so the next request is already presented in the ack cycle.
    assign vram_addr   = base_q + issued_q + {{(VRAM_WADDR_W-1){1'b0}}, vram_ack};
    assign pending_eff = pending_q - LEN_W'(vram_ack);
    // Keep two slots spare after this cycle's write: one for a read possibly in flight.
    assign used_after  = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(push);
    assign vram_strobe = (state_q == ST_FETCH) && (pending_eff != '0) &&
                         (used_after <= (CNT_W+1)'(FIFO_DEPTH - 2));

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

    // FSM next-state and burst bookkeeping.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        issued_d  = issued_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    base_d    = start_addr;
                    pending_d = word_count;
                    issued_d  = '0;
                    if (word_count != '0) state_d = ST_FETCH;
                    else                  done_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_FLUSH;
                end else if (vram_ack) begin
                    issued_d  = issued_q + VRAM_WADDR_W'(1);
                    pending_d = pending_q - LEN_W'(1);
                    if (pending_q == LEN_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and burst registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            issued_q  <= '0;
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            issued_q  <= issued_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    sync_fifo #(
        .WIDTH (VRAM_WDATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fifo_flush),
        .push      (push),
        .push_data (vram_rddata),
        .pop       (rd_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (fifo_count)
    );

endmodule
